jpeg_output_packer: RTL and testbench

Drains the decoder's byte-wide output FIFO through its valid/yumi read port and packs the bytes into LANES-wide words for the downstream stream sink (DMA writer / AXI-stream bridge). The FIFO carries a last-byte flag alongside each data byte, so its WIDTH is IN_W+1. An image ending mid-word produces a zero-padded partial word with byte strobes and last_o. The block is the read side of that FIFO interface.

---
 rtl/jpeg_output_packer_if.sv | 27 ++
 rtl/jpeg_output_packer.sv | 102 ++++++++++
 tb/tb_jpeg_output_packer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_output_packer_if.sv
// Byte-FIFO read port plus packed-word stream port of the output packer.
// The master modport is the packer's side; the slave modport is the environment's side.
interface jpeg_output_packer_if #(
  parameter int IN_W  = 8,
  parameter int LANES = 4
);
  logic [IN_W-1:0]       data_i;
  logic                  last_i;
  logic                  v_i;
  logic                  yumi_o;
  logic                  flush_i;
  logic [IN_W*LANES-1:0] data_o;
  logic [LANES-1:0]      strb_o;
  logic                  last_o;
  logic                  valid_o;
  logic                  accept_i;

  modport master (
    input  data_i, last_i, v_i, flush_i, accept_i,
    output yumi_o, data_o, strb_o, last_o, valid_o
  );

  modport slave (
    output data_i, last_i, v_i, flush_i, accept_i,
    input  yumi_o, data_o, strb_o, last_o, valid_o
  );
endinterface

// File: rtl/jpeg_output_packer.sv
// Packs last-flagged FIFO bytes into LANES-wide little-endian words; word is valid the cycle after its closing byte.
// A closing byte is held in the FIFO while the output word is stalled; filling bytes are always taken.
module jpeg_output_packer #(
  parameter int IN_W  = 8,
  parameter int LANES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  jpeg_output_packer_if.master bus
);
  localparam int OUT_W = IN_W * LANES;
  localparam int CW    = $clog2(LANES);
  localparam int ASM_W = (LANES - 1) * IN_W;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [LANES-1:0] strb_q, strb_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  logic             out_free;
  logic             closing;
  logic             yumi;
  logic [OUT_W-1:0] asm_ext;
  logic [OUT_W-1:0] word;
  logic [LANES-1:0] mask;

  // Top lane of the extended view is never read for the assembled part of a word.
  assign asm_ext = {{IN_W{1'b0}}, asm_q};

  always_comb begin
    out_free = ~valid_q | bus.accept_i;
    closing  = (cnt_q == CW'(LANES - 1)) | bus.last_i;
    yumi     = rst_ni & ~bus.flush_i & bus.v_i & (~closing | out_free);

    word = '0;
    mask = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(cnt_q)) begin
        word[k*IN_W +: IN_W] = asm_ext[k*IN_W +: IN_W];
      end else if (k == int'(cnt_q)) begin
        word[k*IN_W +: IN_W] = bus.data_i;
      end
      mask[k] = (k <= int'(cnt_q));
    end

    cnt_d   = cnt_q;
    asm_d   = asm_q;
    data_d  = data_q;
    strb_d  = strb_q;
    last_d  = last_q;
    valid_d = valid_q;

    if (valid_q && bus.accept_i) begin
      valid_d = 1'b0;
    end

    if (yumi) begin
      if (closing) begin
        // A close in the same cycle as a handoff reloads and keeps the word valid.
        data_d  = word;
        strb_d  = mask;
        last_d  = bus.last_i;
        valid_d = 1'b1;
        cnt_d   = '0;
        asm_d   = '0;
      end else begin
        for (int k = 0; k < LANES - 1; k++) begin
          if (k == int'(cnt_q)) begin
            asm_d[k*IN_W +: IN_W] = bus.data_i;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.flush_i) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.yumi_o  = yumi;
  assign bus.data_o  = data_q;
  assign bus.strb_o  = strb_q;
  assign bus.last_o  = last_q;
  assign bus.valid_o = valid_q;
endmodule

// File: tb/tb_jpeg_output_packer.sv
// Directed and random checks of jpeg_output_packer against a word scoreboard.
module tb_jpeg_output_packer;
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  jpeg_output_packer_if #(.IN_W(8), .LANES(4)) bus ();

  jpeg_output_packer #(.IN_W(8), .LANES(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus.master)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_valid_cyc = -1;
  logic samp_valid;
  int samp_cyc;
  logic [36:0] exp_q[$];
  logic prev_stall = 1'b0;
  logic [36:0] prev_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] wrd(input logic [31:0] d, input logic [3:0] s, input logic l);
    return {l, s, d};
  endfunction

  // Monitor: pops the scoreboard on each handoff and checks stalled words hold.
  always @(negedge clk) begin
    logic [36:0] cur;
    cur = {bus.last_o, bus.strb_o, bus.data_o};
    if (prev_stall) chk("hold_stable", {26'h0, bus.valid_o, cur}, {26'h0, 1'b1, prev_word});
    if (bus.valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.valid_o && bus.accept_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none", cur);
      end else begin
        chk("word", {27'h0, cur}, {27'h0, exp_q.pop_front()});
      end
    end
    prev_stall = bus.valid_o & ~bus.accept_i & rst_ni & ~bus.flush_i;
    prev_word  = cur;
  end

  // Called at posedge+1; drives one cycle and samples yumi_o/valid_o mid-cycle.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic acc,
                       input logic fl, output logic y);
    bus.v_i      = v;
    bus.data_i   = d;
    bus.last_i   = l;
    bus.accept_i = acc;
    bus.flush_i  = fl;
    @(negedge clk);
    y          = bus.yumi_o;
    samp_valid = bus.valid_o;
    samp_cyc   = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l, input logic acc,
                           output int tries, output int ycyc);
    logic y;
    y = 1'b0;
    tries = 0;
    while (!y && tries < 50) begin
      cycle(1'b1, d, l, acc, 1'b0, y);
      tries++;
    end
    ycyc = samp_cyc;
    if (!y) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: byte %h not consumed, got no yumi expected yumi", d);
    end
  endtask

  task automatic idle(input int n);
    logic y;
    repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, y);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t, yc, tot, fy, n;
    logic y, l, vv, aa;
    logic [7:0] b;
    logic [31:0] w;

    rst_ni = 1'b0;
    bus.v_i = 1'b0; bus.data_i = '0; bus.last_i = 1'b0;
    bus.accept_i = 1'b0; bus.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, y);
    chk("reset_state", {y, samp_valid, bus.data_o, bus.strb_o, bus.last_o}, 64'h0);
    rst_ni = 1'b1;

    // Back-to-back stream
    exp_q.push_back(wrd(32'h04030201, 4'hF, 1'b0));
    exp_q.push_back(wrd(32'h08070605, 4'hF, 1'b1));
    first_valid_cyc = -1;
    tot = 0;
    fy = 0;
    for (int i = 1; i <= 8; i++) begin
      push_byte(8'(i), (i == 8), 1'b1, t, yc);
      tot += t;
      if (i == 1) fy = yc;
    end
    chk("t1_yumi_run", tot, 8);
    idle(2);
    chk("t1_latency", first_valid_cyc - fy + 1, 5);

    // Partial tail, then next byte restarts at lane 0
    exp_q.push_back(wrd(32'h14131211, 4'hF, 1'b0));
    exp_q.push_back(wrd(32'h00000015, 4'h1, 1'b1));
    exp_q.push_back(wrd(32'h000000AA, 4'h1, 1'b1));
    for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i), (i == 4), 1'b1, t, yc);
    push_byte(8'hAA, 1'b1, 1'b1, t, yc);
    idle(2);

    // Backpressure on the closing byte
    exp_q.push_back(wrd(32'h54535251, 4'hF, 1'b0));
    exp_q.push_back(wrd(32'h64636261, 4'hF, 1'b0));
    for (int i = 0; i < 4; i++) push_byte(8'h51 + 8'(i), 1'b0, 1'b0, t, yc);
    for (int i = 0; i < 3; i++) push_byte(8'h61 + 8'(i), 1'b0, 1'b0, t, yc);
    cycle(1'b1, 8'h64, 1'b0, 1'b0, 1'b0, y);
    chk("t3_stall_yumi", y, 0);
    cycle(1'b1, 8'h64, 1'b0, 1'b1, 1'b0, y);
    chk("t3_release_yumi", y, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, y);
    chk("t3_no_gap", samp_valid, 1);
    idle(2);

    // Consecutive last bytes
    exp_q.push_back(wrd(32'h00000021, 4'h1, 1'b1));
    exp_q.push_back(wrd(32'h00000022, 4'h1, 1'b1));
    push_byte(8'h21, 1'b1, 1'b1, t, yc);
    push_byte(8'h22, 1'b1, 1'b1, t, yc);
    idle(2);

    // Flush mid-word
    push_byte(8'h31, 1'b0, 1'b1, t, yc);
    push_byte(8'h32, 1'b0, 1'b1, t, yc);
    cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, y);
    chk("t5_flush_yumi", y, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, y);
    chk("t5_no_word", samp_valid, 0);
    exp_q.push_back(wrd(32'h44434241, 4'hF, 1'b0));
    for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i), 1'b0, 1'b1, t, yc);
    idle(2);

    // Reset with a pending word and two assembled lanes
    for (int i = 0; i < 4; i++) push_byte(8'h71 + 8'(i), 1'b0, 1'b0, t, yc);
    push_byte(8'h81, 1'b0, 1'b0, t, yc);
    push_byte(8'h82, 1'b0, 1'b0, t, yc);
    rst_ni = 1'b0;
    cycle(1'b1, 8'h83, 1'b0, 1'b0, 1'b0, y);
    chk("t6_yumi_in_reset", y, 0);
    cycle(1'b1, 8'h83, 1'b0, 1'b1, 1'b0, y);
    chk("t6_outputs_cleared", {y, samp_valid, bus.data_o, bus.strb_o, bus.last_o}, 64'h0);
    rst_ni = 1'b1;
    exp_q.push_back(wrd(32'h00000091, 4'h1, 1'b1));
    push_byte(8'h91, 1'b1, 1'b1, t, yc);
    idle(2);

    // Random bubbles and backpressure against a packing model
    w = '0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      l = (i == 39) || ($urandom % 6 == 0);
      w = w | (32'(b) << (8 * n));
      n++;
      if (n == 4 || l) begin
        exp_q.push_back({l, 4'((1 << n) - 1), w});
        w = '0;
        n = 0;
      end
      y = 1'b0;
      t = 0;
      while (!y && t < 200) begin
        vv = ($urandom % 4) != 0;
        aa = 1'($urandom % 2);
        cycle(vv, vv ? b : 8'h00, vv ? l : 1'b0, aa, 1'b0, y);
        y = y & vv;
        t++;
      end
      if (!y) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout: byte %0d not consumed, got no yumi expected yumi", i);
      end
    end
    repeat (6) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, y);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
